// File: rtl/dds_pkg.sv
// -----------------------------------------------------------------------------
// dds_pkg
// Shared definitions for the DDS phase accumulator slice.
//   ACC_W_DEF  : default accumulator / tuning word width
//   ADDR_W_DEF : default quarter-wave LUT address width
//   quad_e     : quadrant encoding taken from the two phase MSBs
// -----------------------------------------------------------------------------
package dds_pkg;

  localparam int ACC_W_DEF  = 24;
  localparam int ADDR_W_DEF = 8;

  // Q0: rising positive, Q1: falling positive,
  // Q2: falling negative, Q3: rising negative
  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quad_e;

endpackage

// File: rtl/dds_quad_fold.sv
// -----------------------------------------------------------------------------
// dds_quad_fold
// Folds the top bits of a phase word onto a quarter-wave sine table.
//   i_quad_bits : phase MSBs, {quadrant[1:0], table index[ADDR_W-1:0]}
//   o_addr      : table address, mirrored in the falling quadrants (Q1, Q3)
//   o_neg       : sample belongs to the negative half-cycle (Q2, Q3)
// Purely combinational; the caller passes only the bits that matter so no
// phase bits below the table resolution reach this block.
// -----------------------------------------------------------------------------
module dds_quad_fold
  import dds_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [ADDR_W+1:0] i_quad_bits,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_neg
);

  quad_e             w_quad;
  logic [ADDR_W-1:0] w_idx;

  assign w_quad = quad_e'(i_quad_bits[ADDR_W+1 -: 2]);
  assign w_idx  = i_quad_bits[ADDR_W-1:0];

  always_comb begin
    o_addr = w_idx;
    o_neg  = 1'b0;
    case (w_quad)
      Q0: begin o_addr = w_idx;  o_neg = 1'b0; end
      Q1: begin o_addr = ~w_idx; o_neg = 1'b0; end
      Q2: begin o_addr = w_idx;  o_neg = 1'b1; end
      Q3: begin o_addr = ~w_idx; o_neg = 1'b1; end
      default: begin o_addr = w_idx; o_neg = 1'b0; end
    endcase
  end

endmodule

// File: rtl/dds_phase_accum.sv
// -----------------------------------------------------------------------------
// dds_phase_accum
// DDS phase accumulator advanced on rising edges of a divided sample tick.
//   clk_in           : system clock, rising edge
//   rst_in           : asynchronous active-high reset
//   tick_in          : divided sample clock; each rising edge is one strobe
//   run_in           : accumulation enable
//   clr_in           : synchronous accumulator clear (overrides a strobe)
//   fcw_in/fcw_valid : tuning word offer
//   fcw_ready        : high while no tuning word is pending
//   phase_out        : accumulator value
//   lut_addr_out     : folded quarter-wave LUT address
//   lut_neg_out      : negative half-cycle flag
//   sample_valid_out : one-cycle pulse per accumulated sample
//   wrap_out         : one-cycle pulse when that sample overflowed
// A new tuning word waits in a one-deep pending slot and becomes active at the
// next strobe (that strobe already uses it). ACC_W must be >= ADDR_W + 2.
// -----------------------------------------------------------------------------
module dds_phase_accum
  import dds_pkg::*;
#(
  parameter int ACC_W  = ACC_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              tick_in,
  input  logic              run_in,
  input  logic              clr_in,
  input  logic [ACC_W-1:0]  fcw_in,
  input  logic              fcw_valid,
  output logic              fcw_ready,
  output logic [ACC_W-1:0]  phase_out,
  output logic [ADDR_W-1:0] lut_addr_out,
  output logic              lut_neg_out,
  output logic              sample_valid_out,
  output logic              wrap_out
);

  logic             r_tick_q;
  logic             r_pend_vld;
  logic [ACC_W-1:0] r_pend_word;
  logic [ACC_W-1:0] r_active;
  logic [ACC_W-1:0] r_acc;
  logic             r_vld_p1;
  logic             r_wrap_p1;

  logic             w_strobe;
  logic             w_xfer;
  logic [ACC_W-1:0] w_fcw_use;
  logic [ACC_W:0]   w_add;

  // ---- stage p0: strobe detect, handshake, word select, addition ----
  assign w_strobe  = tick_in & ~r_tick_q;
  assign w_xfer    = fcw_valid & ~r_pend_vld;
  // A pending word is consumed by the very strobe that activates it.
  assign w_fcw_use = r_pend_vld ? r_pend_word : r_active;
  assign w_add     = {1'b0, r_acc} + {1'b0, w_fcw_use};

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      // tick_q starts high so a tick already high at release is not a strobe
      r_tick_q    <= 1'b1;
      r_pend_vld  <= 1'b0;
      r_pend_word <= '0;
      r_active    <= '0;
      r_acc       <= '0;
      r_vld_p1    <= 1'b0;
      r_wrap_p1   <= 1'b0;
    end else begin
      r_tick_q  <= tick_in;
      r_vld_p1  <= 1'b0;
      r_wrap_p1 <= 1'b0;

      // Pending word moves to active on any strobe, even when not running.
      if (w_strobe && r_pend_vld) begin
        r_active   <= r_pend_word;
        r_pend_vld <= 1'b0;
      end

      // Transfer only happens with the slot empty, so it never collides
      // with the clear above.
      if (w_xfer) begin
        r_pend_vld  <= 1'b1;
        r_pend_word <= fcw_in;
      end

      if (clr_in) begin
        r_acc <= '0;
      end else if (w_strobe && run_in) begin
        r_acc     <= w_add[ACC_W-1:0];
        r_vld_p1  <= 1'b1;
        r_wrap_p1 <= w_add[ACC_W];
      end
    end
  end

  // ---- stage p1: registered phase, folding and pulses ----
  assign phase_out        = r_acc;
  assign fcw_ready        = ~r_pend_vld;
  assign sample_valid_out = r_vld_p1;
  assign wrap_out         = r_wrap_p1;

  dds_quad_fold #(
    .ADDR_W (ADDR_W)
  ) u_fold (
    .i_quad_bits (r_acc[ACC_W-1 -: ADDR_W+2]),
    .o_addr      (lut_addr_out),
    .o_neg       (lut_neg_out)
  );

endmodule

// File: tb/tb_dds_phase_accum.sv
// -----------------------------------------------------------------------------
// tb_dds_phase_accum
// Scoreboard bench: the driver advances a behavioural model each clock and
// queues every expected sample; a negedge monitor compares the DUT against the
// model state and pops the queue whenever sample_valid_out is high.
// -----------------------------------------------------------------------------
module tb_dds_phase_accum;

  localparam int ACC_W  = 24;
  localparam int ADDR_W = 8;
  localparam longint unsigned MOD  = 64'd1 << ACC_W;
  localparam longint unsigned QTR  = MOD / 4;
  localparam longint unsigned STEP = QTR >> ADDR_W;
  localparam longint unsigned TOP  = (64'd1 << ADDR_W) - 1;

  logic              clk_in = 1'b0;
  logic              rst_in = 1'b1;
  logic              tick_in = 1'b0;
  logic              run_in = 1'b0;
  logic              clr_in = 1'b0;
  logic [ACC_W-1:0]  fcw_in = '0;
  logic              fcw_valid = 1'b0;
  logic              fcw_ready;
  logic [ACC_W-1:0]  phase_out;
  logic [ADDR_W-1:0] lut_addr_out;
  logic              lut_neg_out;
  logic              sample_valid_out;
  logic              wrap_out;

  always #5 clk_in = ~clk_in;

  dds_phase_accum #(
    .ACC_W  (ACC_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .tick_in          (tick_in),
    .run_in           (run_in),
    .clr_in           (clr_in),
    .fcw_in           (fcw_in),
    .fcw_valid        (fcw_valid),
    .fcw_ready        (fcw_ready),
    .phase_out        (phase_out),
    .lut_addr_out     (lut_addr_out),
    .lut_neg_out      (lut_neg_out),
    .sample_valid_out (sample_valid_out),
    .wrap_out         (wrap_out)
  );

  int errs   = 0;
  int checks = 0;

  typedef struct {
    longint unsigned phase;
    bit              wrap;
  } exp_t;
  exp_t sb[$];

  // Model: m_* is the state after the upcoming edge, cur_* the state now shown.
  longint unsigned m_acc = 0, m_active = 0, m_pw = 0;
  bit m_pend = 0, m_tickq = 1, m_valid = 0, m_wrap = 0;
  bit m_xfer = 0, m_strobe = 0;
  longint unsigned cur_acc = 0;
  bit cur_ready = 1, cur_valid = 0, cur_wrap = 0;
  bit mon_en = 0;

  int tick_per = 10;
  int tick_cnt = 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint unsigned f_addr(input longint unsigned a);
    longint unsigned quad, off;
    quad = a / QTR;
    off  = (a % QTR) / STEP;
    return (quad % 2 == 1) ? (TOP - off) : off;
  endfunction

  function automatic bit f_neg(input longint unsigned a);
    return a >= MOD / 2;
  endfunction

  task automatic model_step();
    longint unsigned fsel, sum;
    bit rdy;
    m_xfer   = 0;
    m_strobe = 0;
    if (rst_in) begin
      m_acc = 0; m_active = 0; m_pw = 0; m_pend = 0; m_tickq = 1;
      m_valid = 0; m_wrap = 0;
      cur_acc = 0; cur_ready = 1; cur_valid = 0; cur_wrap = 0;
      sb.delete();
      return;
    end
    cur_acc   = m_acc;
    cur_ready = !m_pend;
    cur_valid = m_valid;
    cur_wrap  = m_wrap;
    rdy       = !m_pend;
    m_strobe  = tick_in && !m_tickq;
    m_tickq   = tick_in;
    m_xfer    = fcw_valid && rdy;
    m_valid   = 0;
    m_wrap    = 0;
    if (m_strobe) begin
      fsel = m_pend ? m_pw : m_active;
      if (m_pend) begin
        m_active = m_pw;
        m_pend   = 0;
      end
      if (!clr_in && run_in) begin
        sum     = m_acc + fsel;
        m_wrap  = (sum >= MOD);
        m_acc   = sum % MOD;
        m_valid = 1;
        sb.push_back('{m_acc, m_wrap});
      end
    end
    if (clr_in) m_acc = 0;
    if (m_xfer) begin
      m_pend = 1;
      m_pw   = longint'(fcw_in);
    end
  endtask

  task automatic cycle();
    tick_in  = (tick_cnt < tick_per / 2);
    tick_cnt = (tick_cnt + 1) % tick_per;
    model_step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic send_fcw(input logic [ACC_W-1:0] w);
    fcw_in    = w;
    fcw_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      cycle();
      if (m_xfer) begin
        fcw_valid = 1'b0;
        return;
      end
    end
    fcw_valid = 1'b0;
    checks++;
    errs++;
    $display("FAIL fcw_timeout: transfer of 0x%0h not accepted within 300 cycles", w);
  endtask

  task automatic run_strobes(input int n);
    int cnt = 0;
    for (int i = 0; i < 40 * n + 40; i++) begin
      cycle();
      if (m_strobe) cnt++;
      if (cnt == n) return;
    end
    checks++;
    errs++;
    $display("FAIL strobe_timeout: saw %0d of %0d strobes", cnt, n);
  endtask

  task automatic to_rise();
    for (int i = 0; i < 20 && tick_cnt != 0; i++) cycle();
  endtask

  task automatic do_reset();
    rst_in    = 1'b1;
    fcw_valid = 1'b0;
    clr_in    = 1'b0;
    #1;
    chk("rst_phase", phase_out, 0);
    chk("rst_ready", fcw_ready, 1);
    chk("rst_valid", sample_valid_out, 0);
    chk("rst_wrap",  wrap_out, 0);
    chk("rst_addr",  lut_addr_out, 0);
    chk("rst_neg",   lut_neg_out, 0);
    tick_per = 10;
    tick_cnt = 1;
    repeat (3) cycle();
    rst_in = 1'b0;
  endtask

  // ---- monitor ----
  always @(negedge clk_in) begin
    if (mon_en) begin
      exp_t e;
      chk("phase", phase_out, cur_acc);
      chk("ready", fcw_ready, cur_ready);
      chk("valid", sample_valid_out, cur_valid);
      chk("wrap_lvl", wrap_out, cur_wrap);
      chk("addr", lut_addr_out, f_addr(cur_acc));
      chk("neg", lut_neg_out, f_neg(cur_acc));
      if (sample_valid_out === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL sb_empty: sample_valid_out=1 with phase 0x%0h, expected no sample", phase_out);
        end else begin
          e = sb.pop_front();
          chk("sb_phase", phase_out, e.phase);
          chk("sb_wrap", wrap_out, e.wrap);
          chk("sb_addr", lut_addr_out, f_addr(e.phase));
        end
      end
    end
  end

  // ---- stimulus ----
  initial begin
    int r;
    repeat (2) @(posedge clk_in);
    #1;
    mon_en = 1;

    // Basic run: 0x100000 per sample, wrap on the 16th
    do_reset();
    run_in = 1'b1;
    send_fcw(24'h100000);
    run_strobes(1);
    chk("r31_first", phase_out, 24'h100000);
    run_strobes(15);
    chk("r31_phase16", phase_out, 0);
    chk("r31_wrap16", wrap_out, 1);
    chk("r31_valid16", sample_valid_out, 1);

    // Folding at 0x410000 and 0xC10000
    do_reset();
    run_in = 1'b1;
    send_fcw(24'h400000);
    run_strobes(1);
    send_fcw(24'h010000);
    run_strobes(1);
    chk("r32_phase_a", phase_out, 24'h410000);
    chk("r32_addr_a", lut_addr_out, 8'hFB);
    chk("r32_neg_a", lut_neg_out, 0);
    send_fcw(24'h800000);
    run_strobes(1);
    chk("r32_phase_b", phase_out, 24'hC10000);
    chk("r32_addr_b", lut_addr_out, 8'hFB);
    chk("r32_neg_b", lut_neg_out, 1);

    // Transfer in the strobe cycle uses the old word
    to_rise();
    send_fcw(24'h000100);
    chk("r33_old_word", phase_out, 24'h410000);
    chk("r33_wrap", wrap_out, 1);
    chk("r33_ready_low", fcw_ready, 0);
    run_strobes(1);
    chk("r33_new_word", phase_out, 24'h410100);
    chk("r33_ready_back", fcw_ready, 1);

    // Second word held while the first is pending
    send_fcw(24'h000200);
    send_fcw(24'h000300);
    chk("r34_first_applied", phase_out, 24'h410300);
    run_strobes(1);
    chk("r34_second_applied", phase_out, 24'h410600);

    // Clear together with a strobe
    to_rise();
    clr_in = 1'b1;
    cycle();
    clr_in = 1'b0;
    chk("r35_phase", phase_out, 0);
    chk("r35_valid", sample_valid_out, 0);
    chk("r35_wrap", wrap_out, 0);

    // Reset mid-run while tick_in is high, with a word pending
    run_strobes(2);
    to_rise();
    cycle();
    fcw_in    = 24'h0ABCDE;
    fcw_valid = 1'b1;
    cycle();
    do_reset();
    run_in = 1'b1;
    run_strobes(1);
    chk("r36_no_stale_word", phase_out, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 30) begin
        if ($urandom_range(0, 3) == 0) send_fcw(24'(32'hFF0000 | $urandom_range(0, 65535)));
        else send_fcw(24'($urandom()));
      end else if (r < 36) begin
        run_in = ($urandom_range(0, 3) != 0);
        cycle();
      end else if (r < 40) begin
        clr_in = 1'b1;
        cycle();
        clr_in = 1'b0;
      end else if (r < 42) begin
        do_reset();
      end else if (r < 47) begin
        tick_per = $urandom_range(2, 12);
        tick_cnt = 0;
        cycle();
      end else begin
        repeat ($urandom_range(1, 6)) cycle();
      end
    end

    run_in = 1'b0;
    repeat (4) cycle();
    @(negedge clk_in);
    #1;
    chk("sb_drain", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
